// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor update queue.
package bp_pkg;

    localparam int PC_W      = 32;
    localparam int CNT_W     = 32;
    localparam int DEF_DEPTH = 8;
    localparam int PTR_W     = $clog2(DEF_DEPTH);

    // One resolved branch as held in the queue (default PC width).
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic            mispred;
    } bp_upd_entry_t;

endpackage

// File: rtl/bp_fifo_2w2r.sv
// Generic circular buffer: up to two writes and two reads per cycle, with
// an occupancy count. Writes land at tail/tail+1, reads come from head/head+1.
module bp_fifo_2w2r #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       wr_n,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic [1:0]       rd_n,
    output logic [WIDTH-1:0] rd_data0,
    output logic [WIDTH-1:0] rd_data1,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    // Neighbouring slots, wrapping modulo DEPTH.
    always_comb begin
        head_p1 = head + PTR_W'(1);
        tail_p1 = tail + PTR_W'(1);
    end

    // Storage writes; a clear discards the incoming data as well.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            if (wr_n != 2'd0) mem[tail]    <= wr_data0;
            if (wr_n == 2'd2) mem[tail_p1] <= wr_data1;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(rd_n);
            tail  <= tail + PTR_W'(wr_n);
            count <= count + (PTR_W+1)'(wr_n) - (PTR_W+1)'(rd_n);
        end
    end

    // Read ports are combinational views of the two oldest slots.
    always_comb begin
        rd_data0 = mem[head];
        rd_data1 = mem[head_p1];
    end

endmodule

// File: rtl/bp_update_queue.sv
// Execute-side sender of branch predictor training updates: buffers resolved
// branches in program order and drains them as registered one-cycle pulses.
module bp_update_queue
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = PC_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DRAIN_DUAL = 0,
    parameter int CNT_WIDTH  = CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 enq0_valid,
    input  logic [PC_WIDTH-1:0]  enq0_pc,
    input  logic                 enq0_taken,
    input  logic                 enq0_mispred,
    input  logic                 enq1_valid,
    input  logic [PC_WIDTH-1:0]  enq1_pc,
    input  logic                 enq1_taken,
    input  logic                 enq1_mispred,
    output logic                 enq_ready,
    output logic [PC_WIDTH-1:0]  upd_pc_first,
    output logic                 upd_branch_first,
    output logic                 upd_taken_first,
    output logic [PC_WIDTH-1:0]  upd_pc_second,
    output logic                 upd_branch_second,
    output logic                 upd_taken_second,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int Q_PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                taken;
        logic                mispred;
    } entry_t;

    entry_t             wr0;
    entry_t             wr1;
    entry_t             rd0;
    entry_t             rd1;
    logic [1:0]         wr_n;
    logic [1:0]         rd_n;
    logic [1:0]         mis_n;
    logic [Q_PTR_W:0]   count;

    bp_fifo_2w2r #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .wr_n     (wr_n),
        .wr_data0 (wr0),
        .wr_data1 (wr1),
        .rd_n     (rd_n),
        .rd_data0 (rd0),
        .rd_data1 (rd1),
        .count    (count)
    );

    // Ready needs two free slots at start of cycle; same-cycle drains are ignored.
    always_comb begin
        enq_ready = (count <= (Q_PTR_W+1)'(DEPTH - 2));
    end

    // Enqueue selection; a lone enq1 is compacted onto the tail slot.
    always_comb begin
        wr_n = 2'd0;
        wr0  = '{pc: enq0_pc, taken: enq0_taken, mispred: enq0_mispred};
        wr1  = '{pc: enq1_pc, taken: enq1_taken, mispred: enq1_mispred};
        if (enq_ready && !flush) begin
            unique case ({enq1_valid, enq0_valid})
                2'b01:   wr_n = 2'd1;
                2'b10: begin
                    wr_n = 2'd1;
                    wr0  = wr1;
                end
                2'b11:   wr_n = 2'd2;
                default: wr_n = 2'd0;
            endcase
        end
    end

    // Drain count from start-of-cycle occupancy, and mispredicts among the drained.
    always_comb begin
        rd_n = 2'd0;
        if (!flush && count != '0) begin
            rd_n = (DRAIN_DUAL != 0 && count >= (Q_PTR_W+1)'(2)) ? 2'd2 : 2'd1;
        end
        mis_n = {1'b0, (rd_n != 2'd0) && rd0.mispred} + {1'b0, (rd_n == 2'd2) && rd1.mispred};
    end

    // Registered update ports and wrapping performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_pc_first      <= '0;
            upd_branch_first  <= 1'b0;
            upd_taken_first   <= 1'b0;
            upd_pc_second     <= '0;
            upd_branch_second <= 1'b0;
            upd_taken_second  <= 1'b0;
            branch_cnt        <= '0;
            mispred_cnt       <= '0;
        end else begin
            upd_branch_first  <= (rd_n != 2'd0);
            upd_branch_second <= (rd_n == 2'd2);
            if (rd_n != 2'd0) begin
                upd_pc_first    <= rd0.pc;
                upd_taken_first <= rd0.taken;
            end
            if (rd_n == 2'd2) begin
                upd_pc_second    <= rd1.pc;
                upd_taken_second <= rd1.taken;
            end
            branch_cnt  <= branch_cnt + CNT_WIDTH'(rd_n);
            mispred_cnt <= mispred_cnt + CNT_WIDTH'(mis_n);
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: single- and dual-drain instances share stimulus;
// a queue-level model predicts each update, a monitor checks the DUT outputs.
module tb_bp_update_queue;
    import bp_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic enq0_valid = 1'b0, enq0_taken = 1'b0, enq0_mispred = 1'b0;
    logic enq1_valid = 1'b0, enq1_taken = 1'b0, enq1_mispred = 1'b0;
    logic [31:0] enq0_pc = '0, enq1_pc = '0;

    logic          rdy [2];
    logic [31:0]   pcf [2];
    logic [31:0]   pcs [2];
    logic          bf  [2];
    logic          bs  [2];
    logic          tf  [2];
    logic          ts  [2];
    logic [CW-1:0] bc  [2];
    logic [CW-1:0] mc  [2];

    bp_update_queue #(.PC_WIDTH(32), .DEPTH(DEPTH), .DRAIN_DUAL(0), .CNT_WIDTH(CW)) u_single (
        .clk(clk), .reset(reset), .flush(flush),
        .enq0_valid(enq0_valid), .enq0_pc(enq0_pc), .enq0_taken(enq0_taken), .enq0_mispred(enq0_mispred),
        .enq1_valid(enq1_valid), .enq1_pc(enq1_pc), .enq1_taken(enq1_taken), .enq1_mispred(enq1_mispred),
        .enq_ready(rdy[0]),
        .upd_pc_first(pcf[0]), .upd_branch_first(bf[0]), .upd_taken_first(tf[0]),
        .upd_pc_second(pcs[0]), .upd_branch_second(bs[0]), .upd_taken_second(ts[0]),
        .branch_cnt(bc[0]), .mispred_cnt(mc[0])
    );

    bp_update_queue #(.PC_WIDTH(32), .DEPTH(DEPTH), .DRAIN_DUAL(1), .CNT_WIDTH(CW)) u_dual (
        .clk(clk), .reset(reset), .flush(flush),
        .enq0_valid(enq0_valid), .enq0_pc(enq0_pc), .enq0_taken(enq0_taken), .enq0_mispred(enq0_mispred),
        .enq1_valid(enq1_valid), .enq1_pc(enq1_pc), .enq1_taken(enq1_taken), .enq1_mispred(enq1_mispred),
        .enq_ready(rdy[1]),
        .upd_pc_first(pcf[1]), .upd_branch_first(bf[1]), .upd_taken_first(tf[1]),
        .upd_pc_second(pcs[1]), .upd_branch_second(bs[1]), .upd_taken_second(ts[1]),
        .branch_cnt(bc[1]), .mispred_cnt(mc[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        bp_upd_entry_t b;
        int            cyc;
    } exp_t;

    int   cyc = 0;
    bit   rst_q = 1'b0;
    int   errors = 0;
    int   checks = 0;

    bp_upd_entry_t mq [2][$];   // model queue contents per instance
    exp_t          eq [2][$];   // expected updates, in output order
    bp_upd_entry_t pq [$];      // branches waiting upstream

    logic [CW-1:0] seen_b [2];
    logic [CW-1:0] seen_m [2];
    logic [31:0]   last_pcf [2];
    logic [31:0]   last_pcs [2];
    logic          last_tf [2];
    logic          last_ts [2];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_q = reset;
    end

    // Monitor: compare every presented update against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_q) begin
                chk($sformatf("rst_branch_first[%0d]", d), 32'(bf[d]), 0);
                chk($sformatf("rst_branch_second[%0d]", d), 32'(bs[d]), 0);
                chk($sformatf("rst_pc_first[%0d]", d), pcf[d], 0);
                chk($sformatf("rst_branch_cnt[%0d]", d), 32'(bc[d]), 0);
                chk($sformatf("rst_mispred_cnt[%0d]", d), 32'(mc[d]), 0);
                seen_b[d] = '0;
                seen_m[d] = '0;
                last_pcf[d] = '0;
                last_pcs[d] = '0;
                last_tf[d] = 1'b0;
                last_ts[d] = 1'b0;
            end else begin
                if (bf[d] === 1'b1) begin
                    if (eq[d].size() == 0) begin
                        chk($sformatf("spurious_first[%0d]", d), 32'(bf[d]), 0);
                    end else begin
                        e = eq[d].pop_front();
                        chk($sformatf("first_cycle[%0d]", d), cyc, e.cyc);
                        chk($sformatf("first_pc[%0d]", d), pcf[d], e.b.pc);
                        chk($sformatf("first_taken[%0d]", d), 32'(tf[d]), 32'(e.b.taken));
                        seen_b[d] = seen_b[d] + 1'b1;
                        seen_m[d] = seen_m[d] + CW'(e.b.mispred);
                    end
                    last_pcf[d] = pcf[d];
                    last_tf[d] = tf[d];
                end else begin
                    if (eq[d].size() != 0 && eq[d][0].cyc <= cyc) begin
                        chk($sformatf("missing_first[%0d]", d), 32'(bf[d]), 1);
                        void'(eq[d].pop_front());
                    end
                    chk($sformatf("hold_pc_first[%0d]", d), pcf[d], last_pcf[d]);
                    chk($sformatf("hold_taken_first[%0d]", d), 32'(tf[d]), 32'(last_tf[d]));
                end
                if (bs[d] === 1'b1) begin
                    if (bf[d] !== 1'b1) chk($sformatf("second_without_first[%0d]", d), 32'(bf[d]), 1);
                    if (eq[d].size() == 0) begin
                        chk($sformatf("spurious_second[%0d]", d), 32'(bs[d]), 0);
                    end else begin
                        e = eq[d].pop_front();
                        chk($sformatf("second_cycle[%0d]", d), cyc, e.cyc);
                        chk($sformatf("second_pc[%0d]", d), pcs[d], e.b.pc);
                        chk($sformatf("second_taken[%0d]", d), 32'(ts[d]), 32'(e.b.taken));
                        seen_b[d] = seen_b[d] + 1'b1;
                        seen_m[d] = seen_m[d] + CW'(e.b.mispred);
                    end
                    last_pcs[d] = pcs[d];
                    last_ts[d] = ts[d];
                end else begin
                    if (eq[d].size() != 0 && eq[d][0].cyc <= cyc) begin
                        chk($sformatf("missing_second[%0d]", d), 32'(bs[d]), 1);
                        void'(eq[d].pop_front());
                    end
                    chk($sformatf("hold_pc_second[%0d]", d), pcs[d], last_pcs[d]);
                    chk($sformatf("hold_taken_second[%0d]", d), 32'(ts[d]), 32'(last_ts[d]));
                end
                chk($sformatf("branch_cnt[%0d]", d), 32'(bc[d]), 32'(seen_b[d]));
                chk($sformatf("mispred_cnt[%0d]", d), 32'(mc[d]), 32'(seen_m[d]));
            end
        end
    end

    function automatic bp_upd_entry_t mk(logic [31:0] pc, bit taken, bit mis);
        bp_upd_entry_t b;
        b.pc = pc;
        b.taken = taken;
        b.mispred = mis;
        return b;
    endfunction

    // One cycle of stimulus plus the reference queue model for the coming edge.
    task automatic step(input bit fl, input bit rs, input int maxn, input bit use1);
        bit            rdy_m;
        int            n;
        int            ndr;
        bp_upd_entry_t acc [$];
        exp_t          e;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("enq_ready[%0d]", d), 32'(rdy[d]), 32'((DEPTH - mq[d].size()) >= 2));
        rdy_m = ((DEPTH - mq[0].size()) >= 2) && ((DEPTH - mq[1].size()) >= 2);
        n = rdy_m ? ((maxn < pq.size()) ? maxn : pq.size()) : 0;
        for (int k = 0; k < n; k++) acc.push_back(pq.pop_front());

        reset = rs;
        flush = fl;
        enq0_valid = (n == 2) || (n == 1 && !use1);
        enq1_valid = (n == 2) || (n == 1 && use1);
        enq0_pc = $urandom; enq0_taken = 1'($urandom); enq0_mispred = 1'($urandom);
        enq1_pc = $urandom; enq1_taken = 1'($urandom); enq1_mispred = 1'($urandom);
        if (n == 2 || (n == 1 && !use1)) begin
            enq0_pc = acc[0].pc; enq0_taken = acc[0].taken; enq0_mispred = acc[0].mispred;
        end
        if (n == 2) begin
            enq1_pc = acc[1].pc; enq1_taken = acc[1].taken; enq1_mispred = acc[1].mispred;
        end else if (n == 1 && use1) begin
            enq1_pc = acc[0].pc; enq1_taken = acc[0].taken; enq1_mispred = acc[0].mispred;
        end

        for (int d = 0; d < 2; d++) begin
            if (rs) begin
                mq[d].delete();
                eq[d].delete();
            end else begin
                ndr = fl ? 0 : ((mq[d].size() < (d + 1)) ? mq[d].size() : (d + 1));
                for (int k = 0; k < ndr; k++) begin
                    e.b = mq[d].pop_front();
                    e.cyc = cyc + 1;
                    eq[d].push_back(e);
                end
                if (fl) mq[d].delete();
                else foreach (acc[k]) mq[d].push_back(acc[k]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0);
        idle(1);

        // Single taken branch
        pq.push_back(mk(32'h1000, 1'b1, 1'b0));
        step(1'b0, 1'b0, 2, 1'b0);
        idle(4);

        // Pair with the younger mispredicted
        pq.push_back(mk(32'h10, 1'b0, 1'b0));
        pq.push_back(mk(32'h14, 1'b1, 1'b1));
        step(1'b0, 1'b0, 2, 1'b0);
        idle(4);

        // Fill beyond capacity, excess waits upstream; pointers wrap
        for (int i = 0; i < 12; i++) pq.push_back(mk(32'h4000 + 32'(4 * i), 1'(i), 1'(i % 3 == 0)));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2, 1'b0);
        idle(12);

        // Flush with a valid enq0 after five entries
        for (int i = 0; i < 6; i++) pq.push_back(mk(32'h5000 + 32'(4 * i), 1'b1, 1'b1));
        step(1'b0, 1'b0, 2, 1'b0);
        step(1'b0, 1'b0, 2, 1'b0);
        step(1'b0, 1'b0, 1, 1'b0);
        step(1'b1, 1'b0, 1, 1'b0);
        idle(3);

        // Lone enq1, then enq0
        pq.push_back(mk(32'h20, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1, 1'b1);
        pq.push_back(mk(32'h24, 1'b0, 1'b1));
        step(1'b0, 1'b0, 1, 1'b0);
        idle(4);

        // Randomised traffic with occasional flush and one mid-run reset
        for (int i = 0; i < 700; i++) begin
            if (pq.size() < 6) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                    pq.push_back(mk($urandom, 1'($urandom), 1'($urandom)));
            end
            step(($urandom % 40) == 0, i == 350, int'($urandom_range(0, 2)), 1'($urandom));
        end

        while (pq.size() != 0) step(1'b0, 1'b0, 2, 1'b0);
        idle(12);
        for (int d = 0; d < 2; d++)
            chk($sformatf("leftover_updates[%0d]", d), eq[d].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
